reg_scoreboard: RTL

//  Tracks register-file writes that are in flight between ID and WB; sole source of the RAW/WAW hazard stall for idecode.
//  - ID asks whether the current instruction's sources/dest are pending; the block answers combinationally with hazard_o.
//  - A per-register counter increments when ID issues a writing instruction and decrements when WB retires the write.
//  - Also provides in-flight count, drain status and a sticky protocol-error flag for debug.

---
 rtl/reg_scoreboard_pkg.sv | 17 +
 rtl/sb_counter.sv | 46 ++++
 rtl/reg_scoreboard.sv | 112 +++++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared defaults and hazard-reason encoding for the register scoreboard.
package reg_scoreboard_pkg;

    localparam int unsigned DEF_N_REG   = 16;
    localparam int unsigned DEF_W_RN    = 4;
    localparam int unsigned DEF_W_CNT   = 2;
    localparam int unsigned DEF_CNT_MAX = (2 ** DEF_W_CNT) - 1;

    // Why ID is stalled; priority RS > RD > saturation.
    typedef enum logic [1:0] {
        HZ_NONE = 2'd0,
        HZ_RS   = 2'd1,
        HZ_RD   = 2'd2,
        HZ_SAT  = 2'd3
    } hz_reason_e;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: saturating up/down with a one-cycle error pulse.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned W_CNT = DEF_W_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [W_CNT-1:0] cnt,
    output logic             err_c
);

    localparam logic [W_CNT-1:0] CNT_MAX = '1;

    logic [W_CNT-1:0] cnt_nxt;

    // Simultaneous inc/dec cancel; otherwise hold at the rails and flag it.
    always_comb begin
        cnt_nxt = cnt;
        err_c   = 1'b0;
        if (inc && !dec) begin
            if (cnt == CNT_MAX) begin
                err_c = 1'b1;
            end else begin
                cnt_nxt = cnt + W_CNT'(1);
            end
        end else if (dec && !inc) begin
            if (cnt == '0) begin
                err_c = 1'b1;
            end else begin
                cnt_nxt = cnt - W_CNT'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks in-flight register writes between ID and WB and raises the RAW/WAW stall.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned N_REG = DEF_N_REG,
    parameter int unsigned W_RN  = DEF_W_RN,
    parameter int unsigned W_CNT = DEF_W_CNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_v_i,
    input  logic [W_RN-1:0]       id_rd_num_i,
    input  logic                  id_rd_use_i,
    input  logic [W_RN-1:0]       id_rs_num_i,
    input  logic                  id_rs_use_i,
    input  logic                  id_wb_i,
    input  logic                  id_fire_i,
    input  logic                  wb_v_i,
    input  logic [W_RN-1:0]       wb_rd_num_i,
    output logic                  hazard_o,
    output logic [N_REG-1:0]      busy_o,
    output logic [W_RN+W_CNT-1:0] inflight_o,
    output logic                  drained_o,
    output logic                  err_o
);

    localparam int unsigned      W_INF   = W_RN + W_CNT;
    localparam logic [W_CNT-1:0] CNT_MAX = '1;

    logic [W_CNT-1:0] cnt [N_REG];
    logic [N_REG-1:0] busy;
    logic [N_REG-1:0] inc_vec;
    logic [N_REG-1:0] dec_vec;
    logic [N_REG-1:0] cnt_err;
    logic             inc;
    logic             dec;
    logic             same_reg;
    logic             inc_ok;
    logic             dec_ok;
    logic             err_set;
    hz_reason_e       hz_reason;
    logic [W_INF-1:0] inflight_q;
    logic [W_INF-1:0] inflight_nxt;
    logic             err_q;

    assign inc      = id_fire_i & id_v_i & id_wb_i;
    assign dec      = wb_v_i;
    assign same_reg = inc & dec & (id_rd_num_i == wb_rd_num_i);

    for (genvar g = 0; g < N_REG; g++) begin : g_cnt
        assign inc_vec[g] = inc & (id_rd_num_i == W_RN'(g));
        assign dec_vec[g] = dec & (wb_rd_num_i == W_RN'(g));
        assign busy[g]    = |cnt[g];

        sb_counter #(
            .W_CNT (W_CNT)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_vec[g]),
            .dec   (dec_vec[g]),
            .cnt   (cnt[g]),
            .err_c (cnt_err[g])
        );
    end

    // Stall only on current counters; a same-cycle WB release is not bypassed.
    always_comb begin
        hz_reason = HZ_NONE;
        if (id_v_i) begin
            if (id_rs_use_i && busy[id_rs_num_i]) begin
                hz_reason = HZ_RS;
            end else if (id_rd_use_i && busy[id_rd_num_i]) begin
                hz_reason = HZ_RD;
            end else if (id_wb_i && (cnt[id_rd_num_i] == CNT_MAX)) begin
                hz_reason = HZ_SAT;
            end
        end
    end

    assign hazard_o = (hz_reason != HZ_NONE);

    // Mirror the per-register hold rules so the total always equals sum(cnt).
    always_comb begin
        inc_ok       = inc & ((cnt[id_rd_num_i] != CNT_MAX) | same_reg);
        dec_ok       = dec & ((cnt[wb_rd_num_i] != '0) | same_reg);
        inflight_nxt = inflight_q;
        if (inc_ok && !dec_ok) begin
            inflight_nxt = inflight_q + W_INF'(1);
        end else if (dec_ok && !inc_ok) begin
            inflight_nxt = inflight_q - W_INF'(1);
        end
    end

    assign err_set = (|cnt_err) | (id_fire_i & hazard_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_nxt;
            err_q      <= err_q | err_set;
        end
    end

    assign busy_o     = busy;
    assign inflight_o = inflight_q;
    assign drained_o  = (inflight_q == '0);
    assign err_o      = err_q;

endmodule
